// File: rtl/mole_target_controller.sv
// Whack-a-mole target controller: picks a random LED, times the lit window, judges presses, keeps score.
// Optional build macro MOLE_SPEEDUP_EN shortens the lit window after every hit.
module mole_target_controller #(
  parameter int ON_CYCLES  = 50_000_000,
  parameter int GAP_CYCLES = 10_000_000,
  parameter int MAX_MISS   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] rand_in,
  input  logic [9:0] btn,
  output logic [9:0] led,
  output logic [3:0] target,
  output logic [7:0] score,
  output logic [3:0] miss_cnt,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       game_over
);

  localparam int TW = $clog2(ON_CYCLES) + 1;
  localparam logic [TW-1:0] ON_LEN   = TW'(ON_CYCLES);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
  localparam logic [3:0]    MISS_LIM = 4'(MAX_MISS);

  typedef enum logic [2:0] {IDLE, PICK, SHOW, GAP, OVER} state_t;
  state_t state, state_next;

  logic [9:0]    btn_q;
  logic          start_q;
  logic [3:0]    last_target;
  logic [TW-1:0] timer;
  logic [TW-1:0] on_len;
  logic [9:0]    press;
  logic [9:0]    tgt_mask;
  logic          start_re;
  logic          rand_ok;
  logic          hit;
  logic          miss;

  assign press    = btn & ~btn_q;
  assign start_re = start & ~start_q;
  assign tgt_mask = 10'd1 << target;
  assign rand_ok  = (rand_in < 4'd10) && (rand_in != last_target);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // A wrong button outranks the right one, and the right one outranks the timeout.
  always_comb begin
    state_next = state;
    hit        = 1'b0;
    miss       = 1'b0;
    led        = '0;
    game_over  = 1'b0;
    case (state)
      IDLE: if (start_re) state_next = PICK;
      PICK: if (rand_ok) state_next = SHOW;
      SHOW: begin
        led = tgt_mask;
        if ((press & ~tgt_mask) != '0)      miss = 1'b1;
        else if ((press & tgt_mask) != '0)  hit  = 1'b1;
        else if (timer == '0)               miss = 1'b1;
        if (hit || miss) state_next = GAP;
      end
      GAP: begin
        if (miss_cnt == MISS_LIM) state_next = OVER;
        else if (timer == '0)     state_next = PICK;
      end
      OVER: begin
        led       = 10'h3FF;
        game_over = 1'b1;
        if (start_re) state_next = PICK;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q       <= '0;
      start_q     <= 1'b0;
      last_target <= 4'hF;
      timer       <= '0;
      target      <= '0;
      score       <= '0;
      miss_cnt    <= '0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
    end else begin
      btn_q      <= btn;
      start_q    <= start;
      hit_pulse  <= hit;
      miss_pulse <= miss;
      case (state)
        IDLE, OVER: begin
          if (start_re) begin
            score    <= '0;
            miss_cnt <= '0;
          end
        end
        PICK: begin
          if (rand_ok) begin
            target      <= rand_in;
            last_target <= rand_in;
            timer       <= on_len - TW'(1);
          end
        end
        SHOW: begin
          if (hit) begin
            if (score != 8'hFF) score <= score + 8'd1;
            timer <= GAP_LOAD;
          end else if (miss) begin
            miss_cnt <= miss_cnt + 4'd1;
            timer    <= GAP_LOAD;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        GAP: if (timer != '0) timer <= timer - TW'(1);
        default: ;
      endcase
    end
  end

`ifdef MOLE_SPEEDUP_EN
  localparam logic [TW-1:0] STEP  = TW'(ON_CYCLES >> 4);
  localparam logic [TW-1:0] FLOOR = TW'(ON_CYCLES >> 2);
  logic [TW-1:0] on_len_dec;

  assign on_len_dec = on_len - STEP;

  // Window shrinks per hit but never below a quarter of the base length.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      on_len <= ON_LEN;
    else if (start_re && (state == IDLE || state == OVER))
      on_len <= ON_LEN;
    else if (hit && (on_len_dec >= FLOOR))
      on_len <= on_len_dec;
  end
`else
  assign on_len = ON_LEN;
`endif

endmodule

// File: tb/tb_mole_target_controller.sv
// Self-checking bench for mole_target_controller: directed stimulus, cycle-level reference model.
// Honours MOLE_SPEEDUP_EN so window-length expectations follow the build.
module tb_mole_target_controller;

  localparam int ON   = 16;
  localparam int GAPC = 2;
  localparam int MAXM = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] rand_in = 4'd0;
  logic [9:0] btn = 10'd0;
  logic [9:0] led;
  logic [3:0] target;
  logic [7:0] score;
  logic [3:0] miss_cnt;
  logic       hit_pulse;
  logic       miss_pulse;
  logic       game_over;

  int n_cmp = 0;
  int n_fail = 0;

  mole_target_controller #(.ON_CYCLES(ON), .GAP_CYCLES(GAPC), .MAX_MISS(MAXM)) dut (
    .clk(clk), .reset(reset), .start(start), .rand_in(rand_in), .btn(btn),
    .led(led), .target(target), .score(score), .miss_cnt(miss_cnt),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: game phases tracked by elapsed cycle counts rather than down-counters.
  typedef enum {M_WAIT, M_CHOOSE, M_LIT, M_DARK, M_ENDED} phase_t;
  phase_t     m_phase;
  int         m_cyc, m_mark, m_win, m_cur_win, m_target, m_last, m_score, m_miss;
  int         m_hit_p, m_miss_p;
  logic [9:0] m_prev_btn;
  logic       m_prev_start;

  always @(posedge clk or negedge reset) begin
    logic [9:0] pr;
    logic [9:0] mask;
    bit         sre;
    int         verdict;
    if (!reset) begin
      m_phase = M_WAIT; m_cyc = 0; m_mark = 0; m_win = ON; m_cur_win = ON;
      m_target = 0; m_last = 15; m_score = 0; m_miss = 0;
      m_hit_p = 0; m_miss_p = 0; m_prev_btn = '0; m_prev_start = 1'b0;
    end else begin
      m_cyc++;
      pr = btn & ~m_prev_btn;
      sre = start && !m_prev_start;
      m_hit_p = 0;
      m_miss_p = 0;
      verdict = 0;
      case (m_phase)
        M_WAIT, M_ENDED: begin
          if (sre) begin
            m_score = 0; m_miss = 0; m_win = ON; m_phase = M_CHOOSE;
          end
        end
        M_CHOOSE: begin
          if (rand_in < 10 && int'(rand_in) != m_last) begin
            m_target = int'(rand_in); m_last = m_target;
            m_mark = m_cyc; m_cur_win = m_win; m_phase = M_LIT;
          end
        end
        M_LIT: begin
          mask = 10'd1 << m_target;
          if ((pr & ~mask) != 0)             verdict = 2;
          else if ((pr & mask) != 0)         verdict = 1;
          else if (m_cyc - m_mark == m_cur_win) verdict = 2;
          if (verdict == 1) begin
            m_hit_p = 1;
            m_score = (m_score >= 255) ? 255 : m_score + 1;
`ifdef MOLE_SPEEDUP_EN
            if (m_win - ON / 16 >= ON / 4) m_win = m_win - ON / 16;
`endif
          end else if (verdict == 2) begin
            m_miss_p = 1;
            m_miss = m_miss + 1;
          end
          if (verdict != 0) begin
            m_mark = m_cyc; m_phase = M_DARK;
          end
        end
        M_DARK: begin
          if (m_miss == MAXM)             m_phase = M_ENDED;
          else if (m_cyc - m_mark == GAPC) m_phase = M_CHOOSE;
        end
        default: ;
      endcase
      m_prev_btn = btn;
      m_prev_start = start;
    end
  end

  // Every cycle, away from the active edge, the DUT must agree with the model.
  always @(negedge clk) begin
    logic [9:0] exp_led;
    exp_led = (m_phase == M_LIT) ? (10'd1 << m_target) : (m_phase == M_ENDED) ? 10'h3FF : 10'h000;
    checkOutput("model_led", int'(led), int'(exp_led));
    checkOutput("model_target", int'(target), m_target);
    checkOutput("model_score", int'(score), m_score);
    checkOutput("model_miss_cnt", int'(miss_cnt), m_miss);
    checkOutput("model_hit_pulse", int'(hit_pulse), m_hit_p);
    checkOutput("model_miss_pulse", int'(miss_pulse), m_miss_p);
    checkOutput("model_game_over", int'(game_over), (m_phase == M_ENDED) ? 1 : 0);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic s, input logic [3:0] r, input logic [9:0] b);
    start = s;
    rand_in = r;
    btn = b;
  endtask

  task automatic wait_lit(input string name, input int budget);
    int n = 0;
    while (led == 10'd0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput(name, (led != 10'd0) ? 1 : 0, 1);
  endtask

  function automatic int exp_window(input int hits);
`ifdef MOLE_SPEEDUP_EN
    return (ON - hits * (ON / 16) < ON / 4) ? ON / 4 : ON - hits * (ON / 16);
`else
    return ON + 0 * hits;
`endif
  endfunction

  initial begin
    int k;
    int t;
    int nxt;
    int len;
    $display("[TB] mole_target_controller bench start");
    applyStimulus(1'b0, 4'd0, 10'd0);
    reset = 1'b0;
    repeat (3) tick();
    checkOutput("rst_led", int'(led), 0);
    checkOutput("rst_score", int'(score), 0);
    checkOutput("rst_game_over", int'(game_over), 0);
    reset = 1'b1;
    repeat (2) tick();
    checkOutput("idle_led", int'(led), 0);

    // Start, two invalid samples, then target 4.
    applyStimulus(1'b1, 4'd12, 10'd0); tick();
    applyStimulus(1'b0, 4'd12, 10'd0); tick(); tick();
    checkOutput("pick_hold_led", int'(led), 0);
    applyStimulus(1'b0, 4'd4, 10'd0); tick();
    checkOutput("tgt4_led", int'(led), 'h010);
    checkOutput("tgt4_target", int'(target), 4);
    applyStimulus(1'b0, 4'd4, 10'd1 << 4); tick();
    checkOutput("hit4_pulse", int'(hit_pulse), 1);
    checkOutput("hit4_score", int'(score), 1);

    // Repeat of the previous target must be rejected.
    applyStimulus(1'b0, 4'd4, 10'd0);
    repeat (6) tick();
    checkOutput("reject_repeat_led", int'(led), 0);
    applyStimulus(1'b0, 4'd7, 10'd0);
    wait_lit("wait_tgt7", 8);
    checkOutput("tgt7_target", int'(target), 7);
    repeat (3) tick();
    applyStimulus(1'b0, 4'd2, 10'd1 << 7); tick();
    checkOutput("hit7_pulse", int'(hit_pulse), 1);
    checkOutput("hit7_score", int'(score), 2);
    checkOutput("gap_dark1", int'(led), 0);
    applyStimulus(1'b0, 4'd2, 10'd0); tick();
    checkOutput("gap_dark2", int'(led), 0);
    checkOutput("hit7_pulse_once", int'(hit_pulse), 0);

    // Target 2 times out.
    wait_lit("wait_tgt2", 6);
    k = 0;
    while (miss_pulse == 1'b0 && k < 40) begin
      tick();
      k++;
    end
    checkOutput("timeout_len", k, exp_window(2));
    checkOutput("timeout_miss_cnt", int'(miss_cnt), 1);

    // Held button across SHOW entry is no press; a start edge mid-game is ignored.
    applyStimulus(1'b0, 4'd6, 10'd1 << 6);
    wait_lit("wait_tgt6", 8);
    applyStimulus(1'b1, 4'd6, 10'd1 << 6); tick();
    applyStimulus(1'b0, 4'd6, 10'd1 << 6); tick();
    checkOutput("held_no_hit", int'(hit_pulse), 0);
    checkOutput("held_led", int'(led), 'h040);
    checkOutput("start_ignored_score", int'(score), 2);
    applyStimulus(1'b0, 4'd2, (10'd1 << 6) | (10'd1 << 5)); tick();
    checkOutput("wrong_btn_miss", int'(miss_pulse), 1);
    checkOutput("wrong_btn_cnt", int'(miss_cnt), 2);

    // Right and wrong together is a miss, and the third miss ends the game.
    applyStimulus(1'b0, 4'd2, 10'd0);
    wait_lit("wait_tgt2b", 8);
    applyStimulus(1'b0, 4'd3, (10'd1 << 2) | (10'd1 << 5)); tick();
    checkOutput("both_btn_miss", int'(miss_pulse), 1);
    checkOutput("both_btn_hit", int'(hit_pulse), 0);
    applyStimulus(1'b0, 4'd3, 10'd0); tick();
    checkOutput("over_flag", int'(game_over), 1);
    checkOutput("over_led", int'(led), 'h3FF);
    checkOutput("over_miss_cnt", int'(miss_cnt), 3);
    checkOutput("over_score", int'(score), 2);
    repeat (3) tick();
    checkOutput("over_holds", int'(game_over), 1);
    applyStimulus(1'b1, 4'd8, 10'd0); tick();
    checkOutput("restart_score", int'(score), 0);
    checkOutput("restart_miss", int'(miss_cnt), 0);
    checkOutput("restart_over", int'(game_over), 0);

    // Twenty hits, each pressed in the final cycle of its window.
    for (int i = 0; i < 20; i++) begin
      t = (8 + i * 3) % 10;
      nxt = (8 + (i + 1) * 3) % 10;
      applyStimulus(1'b0, 4'(t), 10'd0);
      wait_lit("wait_win", 10);
      len = exp_window(i);
      repeat (len - 1) tick();
      checkOutput("win_lit_last", int'(led), 1 << t);
      applyStimulus(1'b0, 4'(nxt), 10'd1 << t); tick();
      checkOutput("win_hit_boundary", int'(hit_pulse), 1);
    end
    checkOutput("twenty_score", int'(score), 20);

    // Asynchronous reset in the middle of a lit window.
    applyStimulus(1'b0, 4'd1, 10'd0);
    wait_lit("wait_tgt1", 8);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("async_led", int'(led), 0);
    checkOutput("async_score", int'(score), 0);
    checkOutput("async_target", int'(target), 0);
    checkOutput("async_pulses", int'(hit_pulse) + int'(miss_pulse), 0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    checkOutput("post_reset_idle", int'(led), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mole_target_controller.md
Name: mole_target_controller

Overview:
- Consumer of the 0-9 random stream from random_generator in the LED whack-a-mole game.
- Samples the random index, lights one of 10 LEDs for a timed window, and judges button presses as hits or misses.
- Keeps score and miss count, and declares game over.
- Sits between random_generator, the debounced button block and the LED/7-segment display logic.

Parameters:
ON_CYCLES, 50_000_000, length of the LED-lit window in clk cycles (>=16)
GAP_CYCLES, 10_000_000, dark gap between targets in clk cycles (>=1)
MAX_MISS, 3, number of misses that ends the game (1..15)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  level; rising edge starts or restarts a game
rand_in  input  4  random value from random_generator; values 10..15 are invalid
btn  input  10  debounced buttons, active-high, bit i pairs with led[i]
led  output  10  one-hot target LED
target  output  4  current target index
score  output  8  hit count, saturating
miss_cnt  output  4  miss count
hit_pulse  output  1  one-cycle pulse on a hit
miss_pulse  output  1  one-cycle pulse on a miss
game_over  output  1  high while in OVER

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; led=0, target=0, score=0, miss_cnt=0, hit_pulse=0, miss_pulse=0, game_over=0.
- Reset clears btn_q, start_q, last_target=4'hF, the timer, and on_len=ON_CYCLES.
- Reset mid-game aborts immediately; no pulse is emitted.
- Edge detection: press = btn & ~btn_q and start_re = start & ~start_q. btn_q and start_q are registered every cycle.
- IDLE: led=0. On start_re, clear score and miss_cnt, set on_len=ON_CYCLES, go to PICK.
- PICK: led=0. Each cycle, sample rand_in.
  - Accept if rand_in<10 and rand_in!=last_target: target<=rand_in, last_target<=rand_in, timer<=on_len-1, go to SHOW.
  - Otherwise stay in PICK; the free-running generator supplies a new value next cycle. There is no limit on retries.
- SHOW: led = 1<<target. Evaluated each cycle in this order:
  1. press has any bit other than target set -> miss.
  2. press[target]=1 -> hit.
  3. timer==0 -> miss.
  4. otherwise timer decrements.
- Simultaneous cases:
  - A correct and a wrong press in the same cycle count as a miss.
  - A correct press in the timer==0 cycle counts as a hit.
- Hit: hit_pulse=1 for one cycle; score+1, saturating at 255; timer<=GAP_CYCLES-1; go to GAP.
- Miss: miss_pulse=1 for one cycle; miss_cnt+1; timer<=GAP_CYCLES-1; go to GAP.
- hit_pulse and miss_pulse are registered and assert in the cycle after the decision cycle, aligned with entry to GAP.
- GAP: led=0; presses are ignored.
  - If miss_cnt==MAX_MISS, go to OVER on the first GAP cycle.
  - Else when timer==0, go to PICK; otherwise timer decrements.
- OVER: game_over=1, led=10'h3FF; score and miss_cnt hold. start_re clears counters and goes to PICK.
- start_re in PICK, SHOW or GAP is ignored.
- Buttons held across the SHOW entry do not produce a press; a new rising edge is required.
- Timer width is $clog2(ON_CYCLES)+1 bits.

Optional Feature:
- Macro: MOLE_SPEEDUP_EN.
- Defined: on every hit, on_len <= on_len - (ON_CYCLES>>4) when the result is >= (ON_CYCLES>>2); otherwise on_len is unchanged. The new length takes effect at the next PICK acceptance. on_len resets to ON_CYCLES on game start.
- Undefined: on_len is constant at ON_CYCLES; the subtract logic is absent.

Test Plan (ON_CYCLES=16, GAP_CYCLES=2, MAX_MISS=3):
- Hold reset=0 mid-SHOW with score=5 -> all outputs 0 immediately, state IDLE; after release, led stays 0 until start.
- start pulse, rand_in=12 then 12 then 4 -> PICK holds 2 cycles, target=4, led=10'h010; previous target 4 and rand_in=4 -> rejected until a different value.
- Target 7, btn[7] rises 3 cycles into SHOW -> one hit_pulse, score=1, led=0 for 2 GAP cycles, then PICK.
- Target 2, no press -> miss_pulse after 16 SHOW cycles; btn[5] rise on target 2 -> immediate miss; btn[2]|btn[5] same cycle -> miss.
- Three misses -> game_over=1, led=10'h3FF, miss_cnt=3; start edge -> score=0, miss_cnt=0, PICK.
- MOLE_SPEEDUP_EN: 20 consecutive hits -> window lengths 16,15,...,5,4,4 cycles; without the macro, every window is 16.
